// File: rtl/dmux_pkg.sv
// Shared definitions for the round-robin demultiplexer controller:
// FSM state encoding, channel geometry and a one-hot decode helper.
package dmux_pkg;

  localparam int NCH  = 4;   // number of output channels
  localparam int SELW = 2;   // width of a channel select
  localparam int CNTW = 8;   // width of each delivered-word counter

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Decode a channel number into a one-hot channel vector.
  function automatic logic [NCH-1:0] onehot(input logic [SELW-1:0] s);
    logic [NCH-1:0] v;
    v    = '0;
    v[s] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/dmux_wdt.sv
// Wait-cycle watchdog for the SEND state: counts stalled cycles and flags
// when the count has reached the timeout limit TMO.
module dmux_wdt #(
  parameter int TMO = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [7:0] wcnt;

  // Stall counter: clear wins over increment; the controller stops
  // incrementing once expired, so the count never passes TMO.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all clocked state, so every
    // register samples the values from before this edge.
    if (rst || clr) begin
      wcnt <= '0;
    end else if (inc) begin
      wcnt <= wcnt + 8'd1;
    end
  end

  assign expired = (wcnt == 8'(TMO));

endmodule

// File: rtl/dmux_rr_ctrl.sv
// Controller in front of a 4-way demultiplexer. Accepts one word at a time,
// routes it round-robin or by address, holds it until the selected consumer
// takes it or the watchdog drops it, and keeps per-channel delivery counts
// and sticky timeout flags.
module dmux_rr_ctrl
  import dmux_pkg::*;
#(
  parameter int DW  = 32,
  parameter int TMO = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          mode,
  input  logic [DW-1:0] din,
  input  logic [1:0]    din_dest,
  input  logic          din_valid,
  output logic          din_ready,
  output logic [1:0]    sel,
  output logic [DW-1:0] dout,
  output logic [3:0]    ch_valid,
  input  logic [3:0]    ch_ready,
  output logic [31:0]   cnt,
  output logic [3:0]    err
);

  state_t                state, state_d;
  logic [SELW-1:0]       sel_d, rr_ptr, rr_d, tgt;
  logic [DW-1:0]         dout_d;
  logic [NCH-1:0]        chv_d, err_d;
  logic [NCH*CNTW-1:0]   cnt_d;
  logic                  mode_q, mode_d;
  logic                  wdt_clr, wdt_inc, expired, done;

  // Only combinational output: a word may be offered whenever we sit idle.
  assign din_ready = (state == IDLE) && en && !rst;

  dmux_wdt #(.TMO(TMO)) u_wdt (
    .clk     (clk),
    .rst     (rst),
    .clr     (wdt_clr),
    .inc     (wdt_inc),
    .expired (expired)
  );

  // Next-state and next-output decode for capture, delivery and drop.
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    state_d = state;
    sel_d   = sel;
    rr_d    = rr_ptr;
    dout_d  = dout;
    chv_d   = ch_valid;
    cnt_d   = cnt;
    err_d   = err;
    mode_d  = mode_q;
    wdt_clr = 1'b0;
    wdt_inc = 1'b0;
    done    = 1'b0;
    tgt     = mode ? din_dest : rr_ptr;

    case (state)
      IDLE: begin
        if (din_valid && din_ready) begin
          state_d = SEND;
          sel_d   = tgt;
          dout_d  = din;
          chv_d   = onehot(tgt);
          mode_d  = mode;
          wdt_clr = 1'b1;
        end
      end
      SEND: begin
        // A consumer taking the word on the expiry cycle still counts as
        // a delivery, so ready is tested ahead of the watchdog.
        if (ch_ready[sel]) begin
          cnt_d[sel*CNTW +: CNTW] = cnt[sel*CNTW +: CNTW] + 8'd1;
          done = 1'b1;
        end else if (expired) begin
          err_d[sel] = 1'b1;
          done = 1'b1;
        end else begin
          wdt_inc = 1'b1;
        end
      end
    endcase

    if (done) begin
      state_d = IDLE;
      dout_d  = '0;
      chv_d   = '0;
      if (!mode_q) rr_d = sel + 2'd1;
    end
  end

  // State and registered outputs; reset discards any word in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= '0;
      rr_ptr   <= '0;
      dout     <= '0;
      ch_valid <= '0;
      cnt      <= '0;
      err      <= '0;
      mode_q   <= 1'b0;
    end else begin
      state    <= state_d;
      sel      <= sel_d;
      rr_ptr   <= rr_d;
      dout     <= dout_d;
      ch_valid <= chv_d;
      cnt      <= cnt_d;
      err      <= err_d;
      mode_q   <= mode_d;
    end
  end

endmodule

// File: doc/dmux_rr_ctrl.md
DMUX_RR_CTRL -- requirements
Module: dmux_rr_ctrl

Interface
REQ-001 Parameter DW, default 32: data word width.
REQ-002 Parameter TMO, default 15: maximum wait cycles in SEND before a word is dropped; range 1..255.
REQ-003 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 Port rst  input  1: reset, synchronous and active-high.
REQ-005 Port en  input  1: scheduler enable; gates acceptance of new words only.
REQ-006 Port mode  input  1: 0 = round-robin routing, 1 = addressed routing by din_dest.
REQ-007 Port din  input  DW: input data word.
REQ-008 Port din_dest  input  2: destination channel, used only when mode=1.
REQ-009 Port din_valid  input  1: input word valid.
REQ-010 Port din_ready  output  1: controller can accept a word.
REQ-011 Port sel  output  2: select to the 4-way 32-bit demultiplexer.
REQ-012 Port dout  output  DW: data to the demultiplexer input.
REQ-013 Port ch_valid  output  4: one-hot valid for channels 0..3.
REQ-014 Port ch_ready  input  4: per-channel ready from the consumers.
REQ-015 Port cnt  output  32: four 8-bit delivered-word counters; channel n in bits [8n+7:8n].
REQ-016 Port err  output  4: sticky per-channel timeout flags.

Function
REQ-017 The FSM SHALL have two states: IDLE and SEND.
REQ-018 din_ready SHALL be 1 exactly when state=IDLE, en=1 and rst=0.
REQ-019 On din_valid & din_ready, din SHALL be captured into the holding register.
  - Target: din_dest if mode=1, else the round-robin pointer rr_ptr.
  - sel SHALL take the target value.
  - The state SHALL move to SEND on the next cycle.
  - mode and din_dest are sampled only at capture.
REQ-020 In SEND:
  - dout SHALL equal the held word.
  - ch_valid SHALL be one-hot at bit sel.
REQ-021 In IDLE, dout SHALL be 0 and ch_valid SHALL be 0.
  - sel SHALL hold its last value.
REQ-022 A transfer completes in SEND when ch_ready[sel]=1. On that cycle:
  - cnt[sel] SHALL increment, wrapping 255 to 0.
  - The state SHALL return to IDLE.
  - If mode was 0 at capture, rr_ptr SHALL advance to sel+1, wrapping 3 to 0.
REQ-023 In mode 1, rr_ptr SHALL be unchanged.
REQ-024 Latency: capture to ch_valid is 1 cycle. Peak throughput is 1 word per 2 cycles.
REQ-025 A wait counter SHALL clear on entry to SEND and increment on each SEND cycle with ch_ready[sel]=0.
REQ-026 When the wait counter equals TMO and ch_ready[sel]=0, the word SHALL be dropped:
  - err[sel] SHALL be set.
  - cnt SHALL be unchanged.
  - rr_ptr SHALL advance as in REQ-022 (mode 0 only).
  - The state SHALL return to IDLE.
REQ-027 If ch_ready[sel]=1 on the same cycle the wait counter reaches TMO, the transfer SHALL complete normally and err SHALL NOT be set.
REQ-028 ch_ready bits other than ch_ready[sel] SHALL be ignored.
REQ-029 Deasserting en during SEND SHALL NOT abort the pending word. Only new acceptance is blocked.
REQ-030 err bits SHALL clear only on rst.

Reset
REQ-031 When rst=1 at a clock edge, the following SHALL be cleared regardless of state, including mid-SEND, and the held word SHALL be discarded:
  - state = IDLE
  - sel = 0, rr_ptr = 0
  - dout = 0, ch_valid = 0
  - cnt = 0, err = 0
  - wait counter = 0
REQ-032 din_ready SHALL be 0 during the rst cycle and 1 on the first following cycle if en=1.

Structure
REQ-033 The shared package dmux_pkg SHALL hold:
  - the state encoding (IDLE=0, SEND=1)
  - NCH=4
  - SELW=2
  - CNTW=8
REQ-034 The wait counter and timeout compare SHALL be one sub-module, dmux_wdt (inputs clr, inc; output expired).
REQ-035 All outputs SHALL be registered except din_ready.

Verification
REQ-036 Round-robin flow: mode=0, all ch_ready=1, words 0xA0..0xA7 back-to-back.
  - Response: sel sequence 0,1,2,3,0,1,2,3.
  - Response: cnt=0x02020202, err=0.
REQ-037 Addressed flow: mode=1, dest 3,3,1, ch_ready=4'b1111.
  - Response: ch_valid 4'b1000, 4'b1000, 4'b0010.
  - Response: cnt=0x02000100.
REQ-038 Timeout: ch_ready[2]=0, word to channel 2, TMO=15.
  - Response: ch_valid held 16 cycles.
  - Response: err=4'b0100, cnt byte 2 = 0, then IDLE.
REQ-039 Ready on the expiry cycle: ch_ready[1] rises on the cycle the wait counter equals TMO.
  - Response: transfer completes, err=0, cnt byte 1 incremented.
REQ-040 Wrap: 256 words to channel 0.
  - Response: cnt byte 0 = 0 after the final word, no other byte changed.
REQ-041 Reset mid-SEND: rst=1 while ch_valid=4'b0001, en=0.
  - Response: next cycle ch_valid=0, dout=0, cnt=0, err=0, din_ready=0.
  - Response: after rst=0, rr_ptr=0.
